// File: rtl/intack_pkg.sv
// intack_pkg: shared types and constants for the interrupt-acknowledge sequencer.
package intack_pkg;

    typedef enum logic [2:0] {IDLE, ARB, ACK, REL, HOLD} state_t;

    localparam logic [7:0] AUTOVEC_BASE = 8'd24;
    localparam logic [2:0] LVL_NMI      = 3'd7;

    function automatic logic [7:0] autovec(input logic [2:0] lvl);
        return AUTOVEC_BASE + {5'd0, lvl};
    endfunction

endpackage

// File: rtl/int_ack_master_if.sv
// int_ack_master_if: controller-side and core-side signals of the acknowledge sequencer.
interface int_ack_master_if;

    logic [2:0] ipl_i;
    logic [2:0] cpu_mask_i;
    logic       cpu_boundary_i;
    logic       int_ack_o;
    logic [7:0] wb_dat_i;
    logic       wb_ack_n_i;
    logic       irq_valid_o;
    logic [2:0] irq_level_o;
    logic [7:0] irq_vector_o;
    logic       irq_spurious_o;
    logic       irq_take_i;

    modport master (
        input  ipl_i, cpu_mask_i, cpu_boundary_i, wb_dat_i, wb_ack_n_i, irq_take_i,
        output int_ack_o, irq_valid_o, irq_level_o, irq_vector_o, irq_spurious_o
    );

    modport slave (
        output ipl_i, cpu_mask_i, cpu_boundary_i, wb_dat_i, wb_ack_n_i, irq_take_i,
        input  int_ack_o, irq_valid_o, irq_level_o, irq_vector_o, irq_spurious_o
    );

endinterface

// File: rtl/ipl_qualifier.sv
// ipl_qualifier: mask compare with an edge-armed, non-maskable level 7.
module ipl_qualifier
    import intack_pkg::*;
(
    input  logic       wb_clk_i,
    input  logic       wb_reset_n_i,
    input  logic [2:0] ipl_i,
    input  logic [2:0] cpu_mask_i,
    input  logic       nmi_clr_i,
    output logic       qualify_o
);

    logic nmi_armed;

    // Any cycle away from level 7 re-arms; taking a level-7 request disarms until then.
    always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i)
            nmi_armed <= 1'b1;
        else if (ipl_i != LVL_NMI)
            nmi_armed <= 1'b1;
        else if (nmi_clr_i)
            nmi_armed <= 1'b0;
    end

    assign qualify_o = (ipl_i == LVL_NMI) ? nmi_armed : (ipl_i > cpu_mask_i);

endmodule

// File: rtl/int_ack_master.sv
// int_ack_master: qualifies IPL, runs the acknowledge cycle and presents level/vector to the core.
// Define INTACK_AUTOVEC_EN to supply autovectors (24+level) on timeout instead of SPURIOUS_VEC.
module int_ack_master
    import intack_pkg::*;
#(
    parameter int         ACK_TIMEOUT  = 16,
    parameter logic [7:0] SPURIOUS_VEC = 8'd24
)
(
    input  logic              wb_clk_i,
    input  logic              wb_reset_n_i,
    int_ack_master_if.master  bus
);

    localparam int            CW       = $clog2(ACK_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    state_t        state, state_d;
    logic [2:0]    lvl_r;
    logic [7:0]    vec_r;
    logic          spur_r;
    logic          int_ack_r;
    logic [CW-1:0] cnt_r;
    logic          qualify, latch_lvl, enter_ack, ack_hit, tmo_hit;
    logic [7:0]    tmo_vec;
    logic          tmo_spur;

    ipl_qualifier u_qual (
        .wb_clk_i     (wb_clk_i),
        .wb_reset_n_i (wb_reset_n_i),
        .ipl_i        (bus.ipl_i),
        .cpu_mask_i   (bus.cpu_mask_i),
        .nmi_clr_i    (enter_ack && lvl_r == LVL_NMI),
        .qualify_o    (qualify)
    );

`ifdef INTACK_AUTOVEC_EN
    assign tmo_vec  = autovec(lvl_r);
    assign tmo_spur = 1'b0;
`else
    assign tmo_vec  = SPURIOUS_VEC;
    assign tmo_spur = 1'b1;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = latch_lvl ? ARB : IDLE;
            ARB:     state_d = enter_ack ? ACK : IDLE;
            ACK:     state_d = (ack_hit || tmo_hit) ? REL : ACK;
            REL:     state_d = HOLD;
            HOLD:    state_d = bus.irq_take_i ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        latch_lvl          = state == IDLE && qualify && bus.cpu_boundary_i;
        enter_ack          = state == ARB && bus.ipl_i == lvl_r && qualify;
        ack_hit            = state == ACK && !bus.wb_ack_n_i;
        tmo_hit            = state == ACK && cnt_r == CNT_LAST;
        bus.int_ack_o      = int_ack_r;
        bus.irq_valid_o    = state == HOLD;
        bus.irq_level_o    = lvl_r;
        bus.irq_vector_o   = vec_r;
        bus.irq_spurious_o = spur_r;
    end

    // Ack is tested before timeout so a late ack on the final cycle still wins.
    always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            int_ack_r <= 1'b0;
            lvl_r     <= '0;
            vec_r     <= '0;
            spur_r    <= 1'b0;
            cnt_r     <= '0;
        end else begin
            int_ack_r <= state_d == ACK;
            if (latch_lvl)
                lvl_r <= bus.ipl_i;
            cnt_r <= enter_ack ? '0 : (state == ACK && cnt_r != CNT_LAST) ? cnt_r + CW'(1) : cnt_r;
            if (ack_hit) begin
                vec_r  <= bus.wb_dat_i;
                spur_r <= 1'b0;
            end else if (tmo_hit) begin
                vec_r  <= tmo_vec;
                spur_r <= tmo_spur;
            end
        end
    end

endmodule

// File: tb/tb_int_ack_master.sv
// tb_int_ack_master: directed stimulus with a queued scoreboard checked by an output monitor.
module tb_int_ack_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int_ack_master_if bus();

    int_ack_master #(.ACK_TIMEOUT(16), .SPURIOUS_VEC(8'd24)) dut (
        .wb_clk_i     (clk),
        .wb_reset_n_i (rst_n),
        .bus          (bus)
    );

    typedef struct packed {
        logic [2:0] lvl;
        logic [7:0] vec;
        logic       sp;
    } exp_t;

`ifdef INTACK_AUTOVEC_EN
    localparam logic [7:0] TMO_VEC = 8'd29;
    localparam logic       TMO_SP  = 1'b0;
`else
    localparam logic [7:0] TMO_VEC = 8'd24;
    localparam logic       TMO_SP  = 1'b1;
`endif

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_v = 1'b0;
    exp_t e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each new presentation pops one expected request.
    always @(negedge clk) begin
        if (bus.irq_valid_o && !prev_v) begin
            if (q.size() == 0)
                check("unexpected_irq", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                check("irq_level", 32'(bus.irq_level_o), 32'(e.lvl));
                check("irq_vector", 32'(bus.irq_vector_o), 32'(e.vec));
                check("irq_spurious", 32'(bus.irq_spurious_o), 32'(e.sp));
            end
        end
        prev_v = bus.irq_valid_o;
    end

    task automatic run_ack(input string name, input int ack_after, input int exp_hi);
        int hi = 0;
        int w = 0;
        while (!bus.int_ack_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.int_ack_o) begin
            check({name, "_ack_start"}, 32'd0, 32'd1);
            return;
        end
        while (bus.int_ack_o && hi < 300) begin
            hi++;
            if (ack_after == hi) bus.wb_ack_n_i = 1'b0;
            @(negedge clk);
        end
        bus.wb_ack_n_i = 1'b1;
        check({name, "_ack_len"}, 32'(hi), 32'(exp_hi));
    endtask

    task automatic take(input string name);
        int w = 0;
        while (!bus.irq_valid_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.irq_valid_o) begin
            check({name, "_valid"}, 32'd0, 32'd1);
            return;
        end
        bus.irq_take_i = 1'b1;
        @(negedge clk);
        bus.irq_take_i = 1'b0;
        check({name, "_released"}, 32'(bus.irq_valid_o), 32'd0);
    endtask

    task automatic quiet(input string name, input int n);
        int seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.int_ack_o || bus.irq_valid_o) seen++;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_int_ack"}, 32'(bus.int_ack_o), 32'd0);
        check({name, "_valid"}, 32'(bus.irq_valid_o), 32'd0);
        check({name, "_level"}, 32'(bus.irq_level_o), 32'd0);
        check({name, "_vector"}, 32'(bus.irq_vector_o), 32'd0);
        check({name, "_spurious"}, 32'(bus.irq_spurious_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        bus.ipl_i = 3'd0;
        bus.cpu_mask_i = 3'd0;
        bus.cpu_boundary_i = 1'b0;
        bus.wb_dat_i = 8'd0;
        bus.wb_ack_n_i = 1'b1;
        bus.irq_take_i = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic acknowledge, controller answers one cycle after int_ack rises
        bus.cpu_mask_i = 3'd2;
        bus.cpu_boundary_i = 1'b1;
        bus.wb_dat_i = 8'h1B;
        bus.ipl_i = 3'd3;
        q.push_back('{3'd3, 8'h1B, 1'b0});
        run_ack("t1", 2, 2);
        bus.ipl_i = 3'd0;
        take("t1");

        // Masked level, then edge-sensitive NMI
        bus.ipl_i = 3'd2;
        quiet("t2_masked", 50);
        bus.wb_dat_i = 8'h47;
        bus.ipl_i = 3'd7;
        q.push_back('{3'd7, 8'h47, 1'b0});
        run_ack("t2_nmi", 2, 2);
        take("t2_nmi");
        quiet("t2_nmi_held", 30);
        bus.ipl_i = 3'd0;
        repeat (2) @(negedge clk);
        bus.wb_dat_i = 8'h48;
        bus.ipl_i = 3'd7;
        q.push_back('{3'd7, 8'h48, 1'b0});
        run_ack("t2_rearm", 2, 2);
        bus.ipl_i = 3'd0;
        take("t2_rearm");

        // Timeout
        bus.cpu_mask_i = 3'd0;
        bus.ipl_i = 3'd5;
        q.push_back('{3'd5, TMO_VEC, TMO_SP});
        run_ack("t3_tmo", 0, 16);
        bus.ipl_i = 3'd0;
        take("t3_tmo");

        // One-cycle glitch is rejected in ARB
        bus.ipl_i = 3'd4;
        @(negedge clk);
        bus.ipl_i = 3'd0;
        quiet("t4_glitch", 20);

        // Reset during ACK
        bus.ipl_i = 3'd6;
        w = 0;
        while (!bus.int_ack_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("t5_in_ack", 32'(bus.int_ack_o), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("t5_async");
        bus.ipl_i = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("t5_released");
        bus.wb_dat_i = 8'h77;
        bus.ipl_i = 3'd7;
        q.push_back('{3'd7, 8'h77, 1'b0});
        run_ack("t5_nmi", 2, 2);
        bus.ipl_i = 3'd0;
        take("t5_nmi");

        // Ack on the timeout edge wins
        bus.wb_dat_i = 8'hA5;
        bus.ipl_i = 3'd1;
        q.push_back('{3'd1, 8'hA5, 1'b0});
        run_ack("t6_edge", 16, 16);
        bus.ipl_i = 3'd0;
        take("t6_edge");

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
